// File: rtl/secp256k1_inv_seq_if.sv
// Shared field-ALU port: the sequencer is the master (initiator), the ALU is the slave.
interface secp256k1_inv_seq_if;
   logic         alu_start;
   logic [1:0]   alu_op;
   logic [255:0] alu_a;
   logic [255:0] alu_b;
   logic [255:0] alu_result;
   logic         alu_done;

   modport master (
      output alu_start, alu_op, alu_a, alu_b,
      input  alu_result, alu_done
   );

   modport slave (
      input  alu_start, alu_op, alu_a, alu_b,
      output alu_result, alu_done
   );
endinterface

// File: rtl/secp256k1_inv_seq.sv
// Field inversion a^EXP mod p by left-to-right square-and-multiply over the shared field ALU.
// One MUL is in flight at a time; each ALU wait is bounded by a cycle timeout.
module secp256k1_inv_seq #(
   parameter logic [255:0] EXP     = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D,
   parameter logic [1:0]   OP_MUL  = 2'b10,
   parameter int unsigned  TIMEOUT = 1023
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [255:0]               a_in,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [255:0]               result,
   secp256k1_inv_seq_if.master        alu
);

   localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CHECK     = 3'd1,
      S_SQR_ISSUE = 3'd2,
      S_SQR_WAIT  = 3'd3,
      S_MUL_ISSUE = 3'd4,
      S_MUL_WAIT  = 3'd5,
      S_FINISH    = 3'd6
   } state_t;

   state_t        state_r;
   logic [255:0]  base_r;
   logic [7:0]    idx_r;
   logic [9:0]    tmo_r;

   // Sequencer FSM; alu_a holds the running accumulator between operations.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= S_IDLE;
         base_r        <= 256'd0;
         idx_r         <= 8'd0;
         tmo_r         <= 10'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         result        <= 256'd0;
         alu.alu_start <= 1'b0;
         alu.alu_op    <= OP_MUL;
         alu.alu_a     <= 256'd0;
         alu.alu_b     <= 256'd0;
      end else begin
         done          <= 1'b0;
         alu.alu_start <= 1'b0;
         alu.alu_op    <= OP_MUL;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  base_r  <= a_in;
                  error   <= 1'b0;
                  busy    <= 1'b1;
                  state_r <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (base_r == 256'd0) begin
                  error   <= 1'b1;
                  result  <= 256'd0;
                  done    <= 1'b1;
                  state_r <= S_FINISH;
               end else begin
                  // Bit 255 of EXP is 1, so the accumulator starts at base.
                  idx_r         <= 8'd254;
                  alu.alu_start <= 1'b1;
                  alu.alu_a     <= base_r;
                  alu.alu_b     <= base_r;
                  state_r       <= S_SQR_ISSUE;
               end
            end
            S_SQR_ISSUE: begin
               tmo_r   <= 10'd0;
               state_r <= S_SQR_WAIT;
            end
            S_MUL_ISSUE: begin
               tmo_r   <= 10'd0;
               state_r <= S_MUL_WAIT;
            end
            S_SQR_WAIT, S_MUL_WAIT: begin
               if (alu.alu_done) begin
                  if ((state_r == S_SQR_WAIT) && EXP[idx_r]) begin
                     alu.alu_start <= 1'b1;
                     alu.alu_a     <= alu.alu_result;
                     alu.alu_b     <= base_r;
                     state_r       <= S_MUL_ISSUE;
                  end else if (idx_r == 8'd0) begin
                     result  <= alu.alu_result;
                     done    <= 1'b1;
                     state_r <= S_FINISH;
                  end else begin
                     idx_r         <= idx_r - 8'd1;
                     alu.alu_start <= 1'b1;
                     alu.alu_a     <= alu.alu_result;
                     alu.alu_b     <= alu.alu_result;
                     state_r       <= S_SQR_ISSUE;
                  end
               end else if (tmo_r == TMO_LAST) begin
                  tmo_r   <= tmo_r + 10'd1;
                  error   <= 1'b1;
                  result  <= 256'd0;
                  done    <= 1'b1;
                  state_r <= S_FINISH;
               end else begin
                  tmo_r <= tmo_r + 10'd1;
               end
            end
            S_FINISH: begin
               busy    <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule
